// File: rtl/clock_gating_unit.sv
`timescale 1ns/1ps
// Latch-based glitch-free clock gate with optional disable hold-off and test bypass.
// Define CLOCK_GATING_STATS_EN to add the active_cycles activity counter.
module clock_gating_unit #(
    parameter int HOLD_CYCLES = 0,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             test_en,
    output logic             gated_clk,
    output logic             clk_active
`ifdef CLOCK_GATING_STATS_EN
    ,
    output logic [CNT_W-1:0] active_cycles
`endif
);

    localparam int HOLD_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

    logic hold_active;
    logic en_req;
    logic en_lat;

    generate
        if (HOLD_CYCLES == 0) begin : g_no_hold
            assign hold_active = 1'b0;
        end else begin : g_hold
            logic [HOLD_W-1:0] hold_cnt_q;
            logic [HOLD_W-1:0] hold_cnt_d;

            // Reload while en is high so a re-assertion during hold-off never opens a gap.
            always_comb begin
                hold_cnt_d = hold_cnt_q;
                if (rst) begin
                    hold_cnt_d = '0;
                end else if (en) begin
                    hold_cnt_d = HOLD_W'(HOLD_CYCLES);
                end else if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                hold_cnt_q <= hold_cnt_d;
            end

            assign hold_active = (hold_cnt_q != '0);
        end
    endgenerate

    assign en_req = test_en | (~rst & (en | hold_active));

    // Transparent only while clk is low, so en_lat is frozen for the whole high phase.
    always_latch begin
        if (!clk) begin
            en_lat <= en_req;
        end
    end

    assign gated_clk  = clk & en_lat;
    assign clk_active = en_lat;

`ifdef CLOCK_GATING_STATS_EN
    logic [CNT_W-1:0] act_cnt_q;
    logic [CNT_W-1:0] act_cnt_d;

    always_comb begin
        act_cnt_d = act_cnt_q;
        if (rst) begin
            act_cnt_d = '0;
        end else if (en_lat && (act_cnt_q != {CNT_W{1'b1}})) begin
            act_cnt_d = act_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        act_cnt_q <= act_cnt_d;
    end

    assign active_cycles = act_cnt_q;
`endif

endmodule

// File: tb/tb_clock_gating_unit.sv
`timescale 1ns/1ps
// Bench for clock_gating_unit: two instances (no hold-off, HOLD_CYCLES=2) share stimulus.
module tb_clock_gating_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic test_en = 1'b0;
    logic g0, a0, g2, a2;
`ifdef CLOCK_GATING_STATS_EN
    logic [15:0] c0;
    logic [3:0]  c2;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    clock_gating_unit #(.HOLD_CYCLES(0), .CNT_W(16)) u_h0 (
        .clk(clk), .rst(rst), .en(en), .test_en(test_en),
        .gated_clk(g0), .clk_active(a0)
`ifdef CLOCK_GATING_STATS_EN
        , .active_cycles(c0)
`endif
    );

    clock_gating_unit #(.HOLD_CYCLES(2), .CNT_W(4)) u_h2 (
        .clk(clk), .rst(rst), .en(en), .test_en(test_en),
        .gated_clk(g2), .clk_active(a2)
`ifdef CLOCK_GATING_STATS_EN
        , .active_cycles(c2)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every gated pulse must be a full 5 ns clk-high phase.
    realtime tr0, tr2;
    bit v0 = 1'b0, v2 = 1'b0;
    always @(posedge g0) begin tr0 = $realtime; v0 = 1'b1; end
    always @(posedge g2) begin tr2 = $realtime; v2 = 1'b1; end
    always @(negedge g0) if (v0) begin
        v0 = 1'b0;
        chk("pulse_width_h0", int'(($realtime - tr0) * 1000.0), 32'd5000);
    end
    always @(negedge g2) if (v2) begin
        v2 = 1'b0;
        chk("pulse_width_h2", int'(($realtime - tr2) * 1000.0), 32'd5000);
    end

    // Reference model: an edge passes if bypassed, or not in reset and en is high now,
    // or en was last seen high (since the last reset) no more than HOLD edges ago.
    int k = 0;
    int last_hi = -1;
    int mc0 = 0, mc2 = 0;

    task automatic drive(input bit r, input bit e, input bit t,
                         input bit use_tab, input bit tab0, input bit tab2);
        bit p0, p2;
        @(negedge clk);
        #2;
        rst = r; en = e; test_en = t;
        #1;
        chk("low_phase_h0", g0, 0);
        chk("low_phase_h2", g2, 0);
        @(posedge clk);
        #1;
        p0 = t | (!r & e);
        p2 = t | (!r & (e | (last_hi >= 0 && (k - last_hi) <= 2)));
        if (use_tab) begin
            p0 = tab0;
            p2 = tab2;
        end
        if (r) last_hi = -1;
        else if (e) last_hi = k;
        mc0 = r ? 0 : ((mc0 + p0 > 65535) ? 65535 : mc0 + p0);
        mc2 = r ? 0 : ((mc2 + p2 > 15) ? 15 : mc2 + p2);
        k++;
        chk("gated_h0", g0, p0);
        chk("active_h0", a0, p0);
        chk("gated_h2", g2, p2);
        chk("active_h2", a2, p2);
`ifdef CLOCK_GATING_STATS_EN
        chk("count_h0", c0, mc0);
        chk("count_h2", c2, mc2);
`endif
    endtask

    typedef struct {
        bit r, e, t, x0, x2;
    } vec_t;
    vec_t tab[21];

    initial begin
        tab = '{
            '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1},
            '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1},
            '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1},
            '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1},
            '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0}
        };

        // Reset state after the first edge with rst high and en low.
        #6;
        chk("reset_gated_h0", g0, 0);
        chk("reset_active_h0", a0, 0);
        chk("reset_gated_h2", g2, 0);
        chk("reset_active_h2", a2, 0);
`ifdef CLOCK_GATING_STATS_EN
        chk("reset_count_h0", c0, 0);
        chk("reset_count_h2", c2, 0);
`endif

        for (int i = 0; i < 21; i++) begin
            drive(tab[i].r, tab[i].e, tab[i].t, 1'b1, tab[i].x0, tab[i].x2);
        end

        // en pulsed only during clk high: no pulse now or on the next edge.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        #2;
        chk("midhigh_pulse_h0", g0, 0);
        chk("midhigh_pulse_h2", g2, 0);
        en = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // en falls while gated_clk is high: the current pulse stays intact.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        en = 1'b0;
        #3;
        chk("midhigh_fall_h0", g0, 1);
        chk("midhigh_fall_h2", g2, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset with en held high, then resume on the first edge after release.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with high-phase glitches on every input.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 15) == 0), 1'b0, 1'b0, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                en = ~en;
                rst = $urandom_range(0, 1);
                test_en = $urandom_range(0, 1);
                #2;
                en = ~en;
            end
        end

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #10;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_gating_unit.md
# clock_gating_unit

Glitch-free integrated clock gate (ICG) with an optional disable hold-off. It sits between the free-running system clock and a gated clock domain that the enable can switch off. A latch that is transparent while the clock is low captures a gate enable, and the gate ANDs that latched value with the clock. A scan/test bypass and an optional activity counter are included.

## Interface
- HOLD_CYCLES, 0: extra rising edges passed after `en` deasserts (0 = immediate disable).
- CNT_W, 16: width of `active_cycles` (stats build only).

- clk  input  1  free-running source clock; all registers use its rising edge.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  functional clock enable; may change at any time.
- test_en  input  1  scan/test bypass; forces the gate open regardless of `en` and `rst`.
- gated_clk  output  1  gated clock equal to `clk & en_lat`.
- clk_active  output  1  current latched enable `en_lat`; observability only.
- active_cycles  output  CNT_W  count of passed rising edges; present only with CLOCK_GATING_STATS_EN.

## Operation
- Hold counter `hold_cnt`:
  - Width is clog2(HOLD_CYCLES+1), minimum 1.
  - On each rising edge, apply the first matching rule: rst → 0; else en → HOLD_CYCLES; else if nonzero → decrement.
  - `hold_active` = (hold_cnt != 0). If HOLD_CYCLES = 0, `hold_active` is constant 0.
- Enable request: `en_req = test_en | (~rst & (en | hold_active))`.
- Latch `en_lat`:
  - Level-sensitive and transparent while clk = 0; holds its value while clk = 1.
  - Implemented as a latch primitive, not a flop.
  - Starts at 0 through reset.
- Gate: `gated_clk = clk & en_lat`. No other logic is allowed in the clock path.
- `clk_active` = `en_lat`.
- Reset behaviour:
  - While rst = 1 and test_en = 0, the gate closes from the first clk-low phase onward.
  - `gated_clk` = 0, `clk_active` = 0, hold_cnt = 0, active_cycles = 0.
- test_en = 1 passes clk unconditionally, including during reset.

## Timing
- Enable latency: an `en` rise during clk-low passes the very next rising edge of clk. An `en` rise during clk-high takes effect at the following clk fall, so the first passed rising edge is the next one.
- Disable latency (HOLD_CYCLES = 0): an `en` fall during clk-low blocks the next rising edge. An `en` fall during clk-high leaves the current high pulse intact and blocks from the next edge on.
- With hold-off, after `en` is sampled low, exactly HOLD_CYCLES further rising edges pass; then the gate closes.
- An `en` re-assertion during hold-off reloads the counter, so the gate never closes.
- Glitch freedom: `gated_clk` pulses are always full clk-high phases. No runt pulses are allowed for any `en`, `test_en` or `rst` toggle timing.
- `gated_clk` has zero cycle latency relative to clk; the only added delay is the AND gate.
- Simultaneous rst and en at an edge: rst wins, hold_cnt = 0.

## Configuration
- CLOCK_GATING_STATS_EN defined:
  - `active_cycles` exists.
  - It increments on each rising edge of clk where `en_lat` = 1, i.e. once per passed gated pulse.
  - It saturates at 2^CNT_W−1 and clears synchronously on rst.
- CLOCK_GATING_STATS_EN undefined: the port and the counter are absent. Gating behaviour is otherwise identical.

## Test plan
All scenarios use a 10 ns clk (rise at 5, 15, …), HOLD_CYCLES = 0 unless stated, and rst deasserted after 2 edges.
- Baseline enable: en 0→1 at t=10, 1→0 at t=50 → gated_clk pulses at rises 15, 25, 35, 45 only (4 pulses); clk_active high 10–50.
- Re-enable: en 1 at t=70, 0 at t=100 → pulses at 75, 85, 95; gated_clk low from 100 onward. With stats, active_cycles = 7 total.
- Mid-high toggle: en pulsed 1 from t=6 to t=9 (clk high) → no gated pulse and no glitch. en fall at t=7 while gated_clk is high → that pulse stays a full 5 ns.
- Hold-off: HOLD_CYCLES = 2, en high for 3 edges then low → 5 gated pulses in total, then the gate closes. An en re-pulse during hold-off → no gap.
- Reset: rst = 1 with en = 1 → gated_clk = 0, clk_active = 0, active_cycles = 0. After rst drops, pulses resume on the first following rising edge.
- Test bypass: test_en = 1 with en = 0 and rst = 1 → gated_clk equals clk every cycle.
